// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch: IDLE/RUN/PAUSE FSM, TICK_DIV prescaler, cascaded BCD digits.
// All outputs registered (1-cycle latency from inputs); no backpressure, pulses are always accepted.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 1000000,
    parameter int TICK_W   = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       tick,
    output logic       wrap
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    localparam logic [TICK_W-1:0] TERM = TICK_W'(TICK_DIV - 1);

    state_t            state_q, state_d;
    logic [TICK_W-1:0] presc_q, presc_d;
    logic [3:0]        so_q, so_d, st_q, st_d, mo_q, mo_d, mt_q, mt_d;
    logic              running_q, running_d, tick_q, tick_d, wrap_q, wrap_d;
    logic              inc;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        so_d    = so_q;
        st_d    = st_q;
        mo_d    = mo_q;
        mt_d    = mt_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        inc     = 1'b0;

        case (state_q)
            IDLE: begin
                presc_d = '0;
                if (start_stop) state_d = RUN;
            end
            RUN: begin
                // A pause landing on terminal count still takes the increment.
                if (presc_q == TERM) begin
                    presc_d = '0;
                    inc     = 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
                if (start_stop) state_d = PAUSE;
            end
            PAUSE: begin
                if (clear) begin
                    state_d = IDLE;
                    presc_d = '0;
                    so_d    = 4'd0;
                    st_d    = 4'd0;
                    mo_d    = 4'd0;
                    mt_d    = 4'd0;
                end else if (start_stop) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        // Range checks use >= so a corrupted digit still rolls back into range.
        if (inc) begin
            tick_d = 1'b1;
            if (so_q >= 4'd9) begin
                so_d = 4'd0;
                if (st_q >= 4'd5) begin
                    st_d = 4'd0;
                    if (mo_q >= 4'd9) begin
                        mo_d = 4'd0;
                        if (mt_q >= 4'd5) begin
                            mt_d   = 4'd0;
                            wrap_d = 1'b1;
                        end else begin
                            mt_d = mt_q + 4'd1;
                        end
                    end else begin
                        mo_d = mo_q + 4'd1;
                    end
                end else begin
                    st_d = st_q + 4'd1;
                end
            end else begin
                so_d = so_q + 4'd1;
            end
        end

        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            so_q      <= 4'd0;
            st_q      <= 4'd0;
            mo_q      <= 4'd0;
            mt_q      <= 4'd0;
            running_q <= 1'b0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            so_q      <= so_d;
            st_q      <= st_d;
            mo_q      <= mo_d;
            mt_q      <= mt_d;
            running_q <= running_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
        end
    end

    assign sec_ones = so_q;
    assign sec_tens = st_q;
    assign min_ones = mo_q;
    assign min_tens = mt_q;
    assign running  = running_q;
    assign tick     = tick_q;
    assign wrap     = wrap_q;

endmodule
